div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 93 +++++++++
 tb/tb_div_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Programmable tick divider with optional burst length, start/stop control and a
// cfg_valid/cfg_ready configuration handshake that is open only while idle.
module div_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned DEF_DIV = 10
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   div_q;
  logic [BURST_W-1:0] burst_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   deff_m1;
  logic               tick_now;
  logic               last_tick;
  logic               go;
  logic               tick_d, done_d, busy_d;

  // Ratios 0 and 1 both mean "tick every cycle"
  assign deff_m1   = (div_q < CNT_W'(2)) ? '0 : div_q - CNT_W'(1);
  assign tick_now  = (state == RUN) && (cnt == deff_m1);
  assign last_tick = (burst_q != '0) && ((tick_cnt + BURST_W'(1)) == burst_q);
  assign go        = (state == IDLE) && start && !stop;
  assign cfg_ready = (state == IDLE);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = RUN;
      RUN:     if (stop) state_nxt = IDLE;
               else if (tick_now && last_tick) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    tick_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_nxt != IDLE);
    if (state == RUN && !stop)  tick_d = tick_now;
    if (state == DONE && !stop) done_d = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tick     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      tick_cnt <= '0;
      cnt      <= '0;
      div_q    <= CNT_W'(DEF_DIV);
      burst_q  <= '0;
    end else begin
      tick <= tick_d;
      done <= done_d;
      busy <= busy_d;
      if (cfg_valid && cfg_ready) begin
        div_q   <= cfg_div;
        burst_q <= cfg_burst;
      end
      if (go) begin
        cnt      <= '0;
        tick_cnt <= '0;
      end else if (state == RUN && !stop) begin
        cnt <= tick_now ? '0 : cnt + CNT_W'(1);
        if (tick_now) tick_cnt <= tick_cnt + BURST_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and random checks of div_ctrl against a run-position reference model.
module tb_div_ctrl;

  logic       clk_in = 1'b0;
  logic       rst, cfg_valid, cfg_ready, start, stop, tick, busy, done;
  logic [7:0] cfg_div, cfg_burst, tick_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: position n within the current run
  bit       m_active;
  int       n, md, mb, sd, sb;
  logic [7:0] m_cnt;
  logic     e_tick, e_done;

  div_ctrl #(.CNT_W(8), .BURST_W(8), .DEF_DIV(10)) dut (
    .clk_in(clk_in), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .tick(tick), .busy(busy), .done(done), .tick_cnt(tick_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; n = 0; md = 10; mb = 0; sd = 10; sb = 0;
    m_cnt = '0; e_tick = 0; e_done = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick"},      32'(tick),      32'(e_tick));
    chk({tag, ".done"},      32'(done),      32'(e_done));
    chk({tag, ".busy"},      32'(busy),      32'(m_active));
    chk({tag, ".tick_cnt"},  32'(tick_cnt),  32'(m_cnt));
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!m_active));
  endtask

  task automatic step(input string tag);
    @(posedge clk_in);
    e_tick = 0;
    e_done = 0;
    if (rst) model_reset();
    else if (!m_active) begin
      if (cfg_valid) begin sd = int'(cfg_div); sb = int'(cfg_burst); end
      if (start && !stop) begin
        m_active = 1; n = 0; md = (sd < 2) ? 1 : sd; mb = sb; m_cnt = '0;
      end
    end else if (stop) m_active = 0;
    else begin
      n++;
      if (mb != 0 && n == mb * md + 1) begin
        m_active = 0; e_done = 1;
      end else if (n % md == 0) begin
        e_tick = 1; m_cnt = m_cnt + 8'd1;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int k);
    for (int i = 0; i < k; i++) step(tag);
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; start = 0; stop = 0;
  endtask

  task automatic configure(input int d, input int b);
    cfg_div = 8'(d); cfg_burst = 8'(b); cfg_valid = 1;
    step("cfg");
    cfg_valid = 0;
  endtask

  task automatic do_start(input string tag);
    start = 1; step(tag); start = 0;
  endtask

  task automatic do_stop(input string tag);
    stop = 1; step(tag); stop = 0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    cfg_div = '0; cfg_burst = '0;
    rst = 1;
    #1;
    check_all("reset_async");
    steps("reset", 2);
    #2 rst = 0;
    steps("post_reset_idle", 3);

    // Defaults D=10 continuous
    do_start("def_start");
    steps("def_run", 97);
    chk("def_cnt9", 32'(tick_cnt), 32'd9);
    do_stop("def_stop");
    steps("def_idle", 2);

    // D=4 B=3 burst
    configure(4, 3);
    do_start("b43_start");
    steps("b43_run", 16);
    chk("b43_cnt", 32'(tick_cnt), 32'd3);

    // D=5 continuous, stop after two ticks
    configure(5, 0);
    do_start("d5_start");
    steps("d5_run", 12);
    do_stop("d5_stop");
    chk("d5_ready", 32'(cfg_ready), 32'd1);
    steps("d5_after", 8);

    // cfg and start together; then cfg during RUN is ignored
    cfg_div = 8'd3; cfg_burst = 8'd0; cfg_valid = 1; start = 1;
    step("d3_cfgstart");
    idle_inputs();
    steps("d3_run", 4);
    cfg_div = 8'd7; cfg_valid = 1;
    step("d3_cfg_in_run");
    cfg_valid = 0;
    steps("d3_run2", 12);
    do_stop("d3_stop");

    // start+stop in IDLE: stop wins
    start = 1; stop = 1;
    step("startstop");
    idle_inputs();
    steps("startstop_idle", 2);

    // D=0 and D=1 tick every cycle
    configure(0, 0);
    do_start("d0_start");
    steps("d0_run", 6);
    do_stop("d0_stop");
    configure(1, 1);
    do_start("d1b1_start");
    steps("d1b1_run", 4);

    // Reset mid-burst
    configure(4, 5);
    do_start("rst_start");
    steps("rst_run", 10);
    rst = 1;
    #1;
    model_reset();
    check_all("rst_mid_async");
    steps("rst_mid_hold", 2);
    #2 rst = 0;
    steps("rst_mid_idle", 3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_div   = 8'($urandom_range(0, 6));
      cfg_burst = 8'($urandom_range(0, 4));
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 29) == 0);
      step("rand");
    end
    idle_inputs();
    steps("rand_tail", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
